bpu_dual_slot_pred: RTL and testbench
=====================================

// Module: bpu_dual_slot_pred
// PURPOSE
//  Next-generation fetch-stage branch predictor: parametrised BHT+BTB covering both 4-byte slots of an 8-byte fetch block.
//  Lifts the aligned-pc-only limit: a lookup at pc[2]=1 predicts slot1 only; at pc[2]=0 it picks the first taken slot.
//  Result is registered one cycle after the pc handshake and feeds the pc generator.
//  Counters and targets are trained in place from the update port driven by the branch unit.
// PARAMETERS
//  ENTRIES   64  entries per slot bank; power of two, >=4; IDX_W=$clog2(ENTRIES)
//  TAG_W     12  stored tag bits, taken from pc[IDX_W+3 +: TAG_W]
//  TGT_W     32  stored target bits; predict_target[63:TGT_W] = lookup pc[63:TGT_W]
//  CNT_W      2  saturating counter width; taken when counter MSB=1
// PORTS
//  clock           in   1      rising-edge clock
//  reset           in   1      asynchronous, active-high reset
//  pc              in   64     fetch address
//  pc_handshake    in   1      lookup request for pc this cycle
//  flush           in   1      kill lookup in flight; next-cycle predict_valid=0
//  clear           in   1      invalidate all entries (one cycle)
//  upd_valid       in   1      training write this cycle
//  upd_pc          in   64     pc of the resolved branch; upd_pc[2] selects bank
//  upd_taken       in   1      actual direction
//  upd_target      in   64     actual target (bits [TGT_W-1:0] stored)
//  trigger_pc      out  64     pc of the predicted-taken slot (8-byte block base + 4*slot)
//  predict_target  out  64     predicted target
//  predict_valid   out  1      prediction valid this cycle (single-cycle pulse per lookup)
// BEHAVIOUR
//  - Reset: all valid bits 0; counters = 'b01 (weakly not-taken); predict_valid=0; trigger_pc=0; predict_target=0.
//  - Index = pc[IDX_W+2:3]; tag = pc[IDX_W+3 +: TAG_W]; the same index and tag are used in both banks.
//  - Lookup (cycle N, pc_handshake=1): read both banks; slot s hits if valid & tag match & cnt[MSB]=1.
//    Slot0 is eligible only when pc[2]=0. Winner is the lowest eligible hit slot.
//  - Cycle N+1: predict_valid=1 iff a winner exists, flush=0 in cycle N or N+1, and predict_target[1:0]==0.
//    trigger_pc={pc[63:3],s,2'b00}; predict_target={pc[63:TGT_W],tgt}.
//  - A target with [2]=1 is legal (unlike previous generation); bits[1:0]!=0 marks a corrupt entry and suppresses prediction.
//  - pc_handshake=0 -> next-cycle predict_valid=0; trigger_pc/predict_target hold their last values.
//  - Update (upd_valid=1), single cycle, bank b=upd_pc[2]:
//    hit (valid & tag match): cnt saturating +1 if taken, -1 if not taken (clamped at 0 and 2^CNT_W-1).
//    If taken, the target is overwritten.
//    miss & taken: allocate (overwrite); valid=1; tag, target written; cnt='b10 (weakly taken).
//    miss & not taken: no write.
//  - Lookup and update to the same entry in the same cycle: lookup returns pre-update data (read-before-write, no bypass).
//  - clear: all valid bits 0 on the next edge; counters are untouched.
//    clear beats a same-cycle update; a same-cycle lookup still sees old contents.
//  - flush and pc_handshake together: the new lookup is dropped (predict_valid=0 next cycle).
//  - Reset asserted mid-lookup: outputs go to reset values immediately (async); no pending result survives.
// STRUCTURE
//  - Shared package bpu_pkg: entry struct {valid, tag, target, cnt} and constants CNT_WEAK_T='b10, CNT_WEAK_NT='b01.
//    Also holds the index/tag extraction helper functions.
//  - Sub-module bpu_slot_bank (instantiated twice):
//    flop-array storage, combinational read, one write port with counter update logic, clear input.
//  - Top level: slot select and priority, output register, flush handling.
// TESTING
//  1. Reset, lookup pc=0x8000_0000 -> predict_valid=0 next cycle; all outputs 0 during reset.
//  2. upd pc=0x8000_0004 taken tgt=0x8000_0100, then lookup pc=0x8000_0000 ->
//     predict_valid=1, trigger_pc=0x8000_0004, predict_target=0x8000_0100.
//  3. Train slot0 (pc 0x8000_0000, tgt 0x200) and slot1 taken;
//     lookup pc=0x8000_0000 -> trigger 0x8000_0000; lookup pc=0x8000_0004 -> trigger 0x8000_0004.
//  4. Allocate taken (cnt=10), one not-taken update -> lookup miss; second not-taken -> cnt=00;
//     3 taken -> cnt saturates at 11; one not-taken -> still predicts.
//  5. Same-cycle lookup+allocate on the same entry -> no prediction; repeat lookup next cycle -> prediction.
//  6. clear with a same-cycle update -> all lookups miss afterwards;
//     flush in the cycle after a hitting lookup -> predict_valid=0; aliasing tag (differs in bit IDX_W+3) -> miss.

Source files
------------

// File: rtl/bpu_pkg.sv
// Shared helpers for the dual-slot branch predictor: counter encodings and
// the pc -> index/tag split used by both the lookup and the training path.
package bpu_pkg;

  localparam logic [1:0] CNT_WEAK_T  = 2'b10;
  localparam logic [1:0] CNT_WEAK_NT = 2'b01;

  // Weakly-taken / weakly-not-taken encodings for any counter width.
  function automatic logic [31:0] cnt_weak(input int cnt_w, input logic taken);
    logic [31:0] half;
    half = 32'd1 << (cnt_w - 1);
    return taken ? half : (half - 32'd1);
  endfunction

  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int idx_w);
    return (pc >> 3) & ((64'd1 << idx_w) - 64'd1);
  endfunction

  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int idx_w,
                                         input int tag_w);
    return (pc >> (idx_w + 3)) & ((64'd1 << tag_w) - 64'd1);
  endfunction

endpackage

// File: rtl/bpu_slot_bank.sv
// One slot bank: flop-array entries with combinational read and a single
// training write port (counter saturation, allocate-on-taken, bulk clear).
module bpu_slot_bank
  import bpu_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = 12,
  parameter int TGT_W = 32,
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic             o_rd_valid,
  output logic [TAG_W-1:0] o_rd_tag,
  output logic [TGT_W-1:0] o_rd_target,
  output logic [CNT_W-1:0] o_rd_cnt,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  logic [TAG_W-1:0] i_wr_tag,
  input  logic             i_wr_taken,
  input  logic [TGT_W-1:0] i_wr_target
);

  localparam int ENTRIES = 1 << IDX_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(cnt_weak(CNT_W, 1'b1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_W'(cnt_weak(CNT_W, 1'b0));

  logic             r_valid  [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [TGT_W-1:0] r_target [ENTRIES];
  logic [CNT_W-1:0] r_cnt    [ENTRIES];

  logic             w_wr_hit;
  logic             w_do_write;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [CNT_W-1:0] w_cnt_next;

  assign o_rd_valid  = r_valid[i_rd_idx];
  assign o_rd_tag    = r_tag[i_rd_idx];
  assign o_rd_target = r_target[i_rd_idx];
  assign o_rd_cnt    = r_cnt[i_rd_idx];

  assign w_cnt_cur  = r_cnt[i_wr_idx];
  assign w_wr_hit   = r_valid[i_wr_idx] && (r_tag[i_wr_idx] == i_wr_tag);
  // A miss that resolved not-taken leaves the entry alone; clear drops the update.
  assign w_do_write = i_wr_en && !i_clear && (w_wr_hit || i_wr_taken);

  always_comb begin
    w_cnt_next = CNT_WT;
    if (w_wr_hit) begin
      w_cnt_next = w_cnt_cur;
      if (i_wr_taken && (w_cnt_cur != CNT_MAX))
        w_cnt_next = w_cnt_cur + CNT_ONE;
      else if (!i_wr_taken && (w_cnt_cur != '0))
        w_cnt_next = w_cnt_cur - CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_cnt[i]    <= CNT_WNT;
      end
    end else if (i_clear) begin
      for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
    end else if (w_do_write) begin
      r_valid[i_wr_idx] <= 1'b1;
      r_tag[i_wr_idx]   <= i_wr_tag;
      r_cnt[i_wr_idx]   <= w_cnt_next;
      if (i_wr_taken) r_target[i_wr_idx] <= i_wr_target;
    end
  end

endmodule

// File: rtl/bpu_dual_slot_pred.sv
// Fetch-stage BHT+BTB over both 4-byte slots of an 8-byte block; the
// first eligible taken slot wins and the result is registered for the pc gen.
module bpu_dual_slot_pred
  import bpu_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 12,
  parameter int TGT_W   = 32,
  parameter int CNT_W   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [63:0] pc,
  input  logic        pc_handshake,
  input  logic        flush,
  input  logic        clear,
  input  logic        upd_valid,
  input  logic [63:0] upd_pc,
  input  logic        upd_taken,
  input  logic [63:0] upd_target,
  output logic [63:0] trigger_pc,
  output logic [63:0] predict_target,
  output logic        predict_valid
);

  localparam int IDX_W = $clog2(ENTRIES);

  // pc_handshake is a one-cycle request with no backpressure: a lookup is
  // accepted whenever it is high and its result is presented the next cycle.
  logic [IDX_W-1:0] w_idx, w_upd_idx;
  logic [TAG_W-1:0] w_tag, w_upd_tag;
  logic             w_rd_valid  [2];
  logic [TAG_W-1:0] w_rd_tag    [2];
  logic [TGT_W-1:0] w_rd_target [2];
  logic [CNT_W-1:0] w_rd_cnt    [2];
  logic [1:0]       w_hit;
  logic             w_elig0, w_win, w_sel, w_pv_next;
  logic [TGT_W-1:0] w_sel_target;
  logic             w_unused;

  logic             r_pv;
  logic [63:0]      r_trigger_pc;
  logic [63:0]      r_predict_target;

  assign w_idx     = IDX_W'(pc_index(pc, IDX_W));
  assign w_tag     = TAG_W'(pc_tag(pc, IDX_W, TAG_W));
  assign w_upd_idx = IDX_W'(pc_index(upd_pc, IDX_W));
  assign w_upd_tag = TAG_W'(pc_tag(upd_pc, IDX_W, TAG_W));

  for (genvar b = 0; b < 2; b++) begin : g_bank
    bpu_slot_bank #(
      .IDX_W(IDX_W), .TAG_W(TAG_W), .TGT_W(TGT_W), .CNT_W(CNT_W)
    ) u_bank (
      .clk         (clock),
      .rst         (reset),
      .i_clear     (clear),
      .i_rd_idx    (w_idx),
      .o_rd_valid  (w_rd_valid[b]),
      .o_rd_tag    (w_rd_tag[b]),
      .o_rd_target (w_rd_target[b]),
      .o_rd_cnt    (w_rd_cnt[b]),
      .i_wr_en     (upd_valid && (upd_pc[2] == 1'(b))),
      .i_wr_idx    (w_upd_idx),
      .i_wr_tag    (w_upd_tag),
      .i_wr_taken  (upd_taken),
      .i_wr_target (upd_target[TGT_W-1:0])
    );
    assign w_hit[b] = w_rd_valid[b] && (w_rd_tag[b] == w_tag) && w_rd_cnt[b][CNT_W-1];
  end

  // Slot0 lies before the fetch pc when pc[2]=1, so it cannot redirect.
  assign w_elig0      = w_hit[0] && !pc[2];
  assign w_win        = w_elig0 || w_hit[1];
  assign w_sel        = !w_elig0;
  assign w_sel_target = w_rd_target[w_sel];
  assign w_pv_next    = pc_handshake && !flush && w_win && (w_sel_target[1:0] == 2'b00);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pv             <= 1'b0;
      r_trigger_pc     <= '0;
      r_predict_target <= '0;
    end else begin
      r_pv <= w_pv_next;
      if (pc_handshake) begin
        r_trigger_pc     <= {pc[63:3], w_sel, 2'b00};
        r_predict_target <= {pc[63:TGT_W], w_sel_target};
      end
    end
  end

  // A flush in the result cycle still kills the prediction.
  assign predict_valid  = r_pv && !flush;
  assign trigger_pc     = r_trigger_pc;
  assign predict_target = r_predict_target;

  assign w_unused = ^{pc[1:0], upd_pc[1:0], upd_target[63:TGT_W]};

endmodule

// File: tb/tb_bpu_dual_slot_pred.sv
// Directed bench for bpu_dual_slot_pred with hand-computed expectations.
module tb_bpu_dual_slot_pred;

  logic        clock = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        pc_handshake;
  logic        flush;
  logic        clear;
  logic        upd_valid;
  logic [63:0] upd_pc;
  logic        upd_taken;
  logic [63:0] upd_target;
  logic [63:0] trigger_pc;
  logic [63:0] predict_target;
  logic        predict_valid;

  int n_vec = 0;
  int n_err = 0;

  bpu_dual_slot_pred dut (
    .clock          (clock),
    .reset          (reset),
    .pc             (pc),
    .pc_handshake   (pc_handshake),
    .flush          (flush),
    .clear          (clear),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .trigger_pc     (trigger_pc),
    .predict_target (predict_target),
    .predict_valid  (predict_valid)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running, want finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; registered outputs are stable then too.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    pc_handshake = 1'b0;
    flush        = 1'b0;
    clear        = 1'b0;
    upd_valid    = 1'b0;
    upd_taken    = 1'b0;
  endtask

  task automatic set_update(input logic [63:0] p, input logic tk, input logic [63:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = p;
    upd_taken  = tk;
    upd_target = tgt;
  endtask

  task automatic do_update(input logic [63:0] p, input logic tk, input logic [63:0] tgt);
    set_update(p, tk, tgt);
    step();
    drive_idle();
  endtask

  task automatic do_lookup(input string tag, input logic [63:0] p, input logic exp_v,
                           input logic [63:0] exp_trig, input logic [63:0] exp_tgt);
    pc           = p;
    pc_handshake = 1'b1;
    step();
    drive_idle();
    check_eq({tag, ".valid"}, 64'(predict_valid), 64'(exp_v));
    if (exp_v) begin
      check_eq({tag, ".trigger"}, trigger_pc, exp_trig);
      check_eq({tag, ".target"}, predict_target, exp_tgt);
    end
  endtask

  initial begin
    reset      = 1'b1;
    pc         = 64'h0;
    upd_pc     = 64'h0;
    upd_target = 64'h0;
    drive_idle();
    #1;
    check_eq("rst.valid", 64'(predict_valid), 64'd0);
    step();
    step();
    check_eq("rst.trigger", trigger_pc, 64'd0);
    check_eq("rst.target", predict_target, 64'd0);
    reset = 1'b0;
    step();

    // 1: empty tables
    do_lookup("t1.empty", 64'h8000_0000, 1'b0, 64'h0, 64'h0);

    // 2: slot1 allocate, aligned lookup picks slot1
    do_update(64'h8000_0004, 1'b1, 64'h8000_0100);
    do_lookup("t2.slot1", 64'h8000_0000, 1'b1, 64'h8000_0004, 64'h8000_0100);

    // hold when no handshake
    step();
    check_eq("hold.valid", 64'(predict_valid), 64'd0);
    check_eq("hold.trigger", trigger_pc, 64'h8000_0004);
    check_eq("hold.target", predict_target, 64'h8000_0100);

    // 3: both slots trained; priority vs. pc[2]
    do_update(64'h8000_0000, 1'b1, 64'h0000_0200);
    do_lookup("t3.slot0", 64'h8000_0000, 1'b1, 64'h8000_0000, 64'h0000_0200);
    do_lookup("t3.pc2", 64'h8000_0004, 1'b1, 64'h8000_0004, 64'h8000_0100);

    // 4: counter walk on a fresh entry (idx 8)
    do_update(64'h8000_0040, 1'b1, 64'h300);   // alloc cnt=10
    do_lookup("t4.alloc", 64'h8000_0040, 1'b1, 64'h8000_0040, 64'h300);
    do_update(64'h8000_0040, 1'b0, 64'h0);     // 01
    do_lookup("t4.nt1", 64'h8000_0040, 1'b0, 64'h0, 64'h0);
    do_update(64'h8000_0040, 1'b0, 64'h0);     // 00
    do_update(64'h8000_0040, 1'b0, 64'h0);     // clamped at 00
    do_update(64'h8000_0040, 1'b1, 64'h300);   // 01
    do_lookup("t4.cnt01", 64'h8000_0040, 1'b0, 64'h0, 64'h0);
    do_update(64'h8000_0040, 1'b1, 64'h300);   // 10
    do_update(64'h8000_0040, 1'b1, 64'h304);   // 11, target overwritten
    do_update(64'h8000_0040, 1'b1, 64'h308);   // saturates at 11
    do_update(64'h8000_0040, 1'b0, 64'h0);     // 10
    do_lookup("t4.sat", 64'h8000_0040, 1'b1, 64'h8000_0040, 64'h308);

    // 5: same-cycle lookup and allocate returns pre-update data
    set_update(64'h8000_0080, 1'b1, 64'h500);
    pc = 64'h8000_0080;
    pc_handshake = 1'b1;
    step();
    drive_idle();
    check_eq("t5.rbw", 64'(predict_valid), 64'd0);
    do_lookup("t5.after", 64'h8000_0080, 1'b1, 64'h8000_0080, 64'h500);

    // corrupt target suppresses; bit2 set is legal
    do_update(64'h8000_00C4, 1'b1, 64'h601);
    do_lookup("corrupt", 64'h8000_00C0, 1'b0, 64'h0, 64'h0);
    do_update(64'h8000_00D0, 1'b1, 64'h8000_0404);
    do_lookup("tgt_bit2", 64'h8000_00D0, 1'b1, 64'h8000_00D0, 64'h8000_0404);

    // 6: aliasing tag (bit IDX_W+3 = 9 differs)
    do_lookup("t6.alias", 64'h8000_0200, 1'b0, 64'h0, 64'h0);

    // flush in the result cycle
    pc = 64'h8000_0000;
    pc_handshake = 1'b1;
    step();
    drive_idle();
    flush = 1'b1;
    #1;
    check_eq("t6.flush_n1", 64'(predict_valid), 64'd0);
    flush = 1'b0;
    #1;
    check_eq("t6.flush_rel", 64'(predict_valid), 64'd1);
    step();

    // flush together with the handshake
    pc = 64'h8000_0000;
    pc_handshake = 1'b1;
    flush = 1'b1;
    step();
    drive_idle();
    check_eq("t6.flush_n", 64'(predict_valid), 64'd0);

    // clear with same-cycle update and lookup: lookup sees old contents
    clear = 1'b1;
    set_update(64'h8000_0100, 1'b1, 64'h700);
    pc = 64'h8000_0000;
    pc_handshake = 1'b1;
    step();
    drive_idle();
    check_eq("t6.clr_look", 64'(predict_valid), 64'd1);
    check_eq("t6.clr_trig", trigger_pc, 64'h8000_0000);
    do_lookup("t6.clr_s0", 64'h8000_0000, 1'b0, 64'h0, 64'h0);
    do_lookup("t6.clr_s1", 64'h8000_0004, 1'b0, 64'h0, 64'h0);
    do_lookup("t6.clr_upd", 64'h8000_0100, 1'b0, 64'h0, 64'h0);
    do_lookup("t6.clr_cnt", 64'h8000_0040, 1'b0, 64'h0, 64'h0);

    // reallocate after clear, then async reset kills the result immediately
    do_update(64'h8000_0000, 1'b1, 64'h200);
    do_lookup("rst.pre", 64'h8000_0000, 1'b1, 64'h8000_0000, 64'h200);
    reset = 1'b1;
    #1;
    check_eq("rst.async_v", 64'(predict_valid), 64'd0);
    check_eq("rst.async_tr", trigger_pc, 64'd0);
    check_eq("rst.async_tg", predict_target, 64'd0);
    step();
    reset = 1'b0;
    step();
    do_lookup("rst.post", 64'h8000_0000, 1'b0, 64'h0, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
